// File: rtl/dcache.sv
// dcache: two-stage load/store responder backed by a zero-initialised local SRAM.
// Define DCACHE_ALIGN_CHECK_EN to fault misaligned accesses instead of force-aligning them.
module dcache #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lsq_dc_req,
   input  logic [3:0]  lsq_dc_op,
   input  logic [4:0]  lsq_dc_lsqid,
   input  logic [31:0] lsq_dc_addr,
   input  logic [31:0] lsq_dc_wdata,
   input  logic        lsq_dc_flush,
   output logic        dcache_ready,
   output logic        dcache_valid,
   output logic        dcache_error,
   output logic [4:0]  dcache_lsqid,
   output logic [31:0] dcache_rdata
);
   typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FLUSH} state_t;
   localparam int unsigned DEPTH = 2**ADDR_W;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] init_cnt;
   logic [31:0]       mem [DEPTH];

   logic              accept;
   logic              s1_valid;
   logic [3:0]        s1_op;
   logic [4:0]        s1_lsqid;
   logic [31:0]       s1_addr;
   logic [31:0]       s1_wdata;

   logic              s1_store, s1_uns, s1_err, op_bad, range_bad, mis_bad;
   logic [1:0]        s1_size, s1_lane;
   logic [ADDR_W-1:0] s1_idx;
   logic [31:0]       s1_rword, s1_shifted, s1_ld, s1_wlane, s1_wmerge;
   logic [3:0]        s1_be;
   logic              wr_en, resp_fire;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_INIT;
         init_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_INIT) init_cnt <= init_cnt + 1'b1;
      end
   end

   // Flush gates ready combinationally so a request in the flush cycle is refused.
   always_comb begin
      state_d      = state_q;
      dcache_ready = 1'b0;
      case (state_q)
         ST_INIT:  if (init_cnt == '1) state_d = ST_RUN;
         ST_RUN: begin
            dcache_ready = !lsq_dc_flush;
            if (lsq_dc_flush) state_d = ST_FLUSH;
         end
         ST_FLUSH: state_d = lsq_dc_flush ? ST_FLUSH : ST_RUN;
         default:  state_d = ST_INIT;
      endcase
   end

   assign accept = lsq_dc_req && dcache_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_lsqid <= '0;
         s1_addr  <= '0;
         s1_wdata <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_op    <= lsq_dc_op;
            s1_lsqid <= lsq_dc_lsqid;
            s1_addr  <= lsq_dc_addr;
            s1_wdata <= lsq_dc_wdata;
         end
      end
   end

   always_comb begin
      s1_store  = s1_op[3];
      s1_uns    = s1_op[2];
      s1_size   = s1_op[1:0];
      op_bad    = (s1_size == 2'b11) || (s1_uns && (s1_size[1] || s1_store));
      range_bad = |s1_addr[31:ADDR_W+2];
      s1_idx    = s1_addr[ADDR_W+1:2];
      mis_bad   = 1'b0;
`ifdef DCACHE_ALIGN_CHECK_EN
      s1_lane = s1_addr[1:0];
      case (s1_size)
         2'd1:    mis_bad = s1_addr[0];
         2'd2:    mis_bad = |s1_addr[1:0];
         default: mis_bad = 1'b0;
      endcase
`else
      case (s1_size)
         2'd1:    s1_lane = {s1_addr[1], 1'b0};
         2'd2:    s1_lane = 2'b00;
         default: s1_lane = s1_addr[1:0];
      endcase
`endif
      s1_err     = op_bad || range_bad || mis_bad;
      s1_rword   = mem[s1_idx];
      s1_shifted = s1_rword >> {s1_lane, 3'b000};

      case (s1_size)
         2'd0: begin
            s1_ld    = s1_uns ? {24'd0, s1_shifted[7:0]} : {{24{s1_shifted[7]}}, s1_shifted[7:0]};
            s1_be    = 4'b0001 << s1_lane;
            s1_wlane = {4{s1_wdata[7:0]}};
         end
         2'd1: begin
            s1_ld    = s1_uns ? {16'd0, s1_shifted[15:0]} : {{16{s1_shifted[15]}}, s1_shifted[15:0]};
            s1_be    = 4'b0011 << s1_lane;
            s1_wlane = {2{s1_wdata[15:0]}};
         end
         default: begin
            s1_ld    = s1_shifted;
            s1_be    = 4'b1111;
            s1_wlane = s1_wdata;
         end
      endcase

      s1_wmerge = s1_rword;
      for (int unsigned b = 0; b < 4; b++) begin
         if (s1_be[b]) s1_wmerge[8*b +: 8] = s1_wlane[8*b +: 8];
      end
   end

   // Stores in S1 survive a flush; only speculative loads are dropped.
   assign wr_en     = s1_valid && s1_store && !s1_err && !rst;
   assign resp_fire = s1_valid && !(lsq_dc_flush && !s1_store);

   always_ff @(posedge clk) begin
      if (state_q == ST_INIT) mem[init_cnt] <= '0;
      else if (wr_en)         mem[s1_idx]   <= s1_wmerge;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dcache_valid <= 1'b0;
         dcache_error <= 1'b0;
         dcache_lsqid <= '0;
         dcache_rdata <= '0;
      end else begin
         dcache_valid <= resp_fire;
         dcache_error <= resp_fire && s1_err;
         dcache_lsqid <= resp_fire ? s1_lsqid : '0;
         dcache_rdata <= (resp_fire && !s1_err && !s1_store) ? s1_ld : '0;
      end
   end
endmodule

// File: tb/tb_dcache.sv
// Directed self-checking bench for dcache; expected values are hand-computed per scenario.
module tb_dcache;
   localparam logic [3:0] LB = 4'h0, LH = 4'h1, LW = 4'h2, LBU = 4'h4, LHU = 4'h5;
   localparam logic [3:0] SB = 4'h8, SH = 4'h9, SW = 4'hA;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        lsq_dc_req = 1'b0;
   logic [3:0]  lsq_dc_op = '0;
   logic [4:0]  lsq_dc_lsqid = '0;
   logic [31:0] lsq_dc_addr = '0;
   logic [31:0] lsq_dc_wdata = '0;
   logic        lsq_dc_flush = 1'b0;
   logic        dcache_ready, dcache_valid, dcache_error;
   logic [4:0]  dcache_lsqid;
   logic [31:0] dcache_rdata;

   int total = 0;
   int bad = 0;

   dcache #(.ADDR_W(10)) dut (
      .clk(clk), .rst(rst),
      .lsq_dc_req(lsq_dc_req), .lsq_dc_op(lsq_dc_op), .lsq_dc_lsqid(lsq_dc_lsqid),
      .lsq_dc_addr(lsq_dc_addr), .lsq_dc_wdata(lsq_dc_wdata), .lsq_dc_flush(lsq_dc_flush),
      .dcache_ready(dcache_ready), .dcache_valid(dcache_valid), .dcache_error(dcache_error),
      .dcache_lsqid(dcache_lsqid), .dcache_rdata(dcache_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic req, input logic [3:0] op, input logic [4:0] tag,
                        input logic [31:0] addr, input logic [31:0] wdata);
      lsq_dc_req   = req;
      lsq_dc_op    = op;
      lsq_dc_lsqid = tag;
      lsq_dc_addr  = addr;
      lsq_dc_wdata = wdata;
      #1;
   endtask

   task automatic test_reset;
      int not_zero;
      rst = 1'b1;
      drive(1'b0, LB, 5'd0, 32'h0, 32'h0);
      tick; tick;
      total++;
      if (dcache_ready !== 1'b0 || dcache_valid !== 1'b0 || dcache_error !== 1'b0 ||
          dcache_lsqid !== 5'd0 || dcache_rdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_outputs: rdy=%b vld=%b err=%b tag=%0d rdata=%h, want all 0",
                  dcache_ready, dcache_valid, dcache_error, dcache_lsqid, dcache_rdata);
      end
      rst = 1'b0;
      drive(1'b1, LW, 5'd9, 32'h10, 32'h0);
      not_zero = 0;
      for (int i = 0; i < 1024; i++) begin
         if (dcache_ready !== 1'b0) not_zero++;
         tick;
      end
      total++;
      if (not_zero !== 0) begin
         bad++;
         $display("FAIL init_ready_low: ready high in %0d of 1024 init cycles, want 0", not_zero);
      end
      total++;
      if (dcache_ready !== 1'b1) begin
         bad++;
         $display("FAIL first_accept: ready=%b in cycle 1024, want 1", dcache_ready);
      end
      tick;
      drive(1'b0, LB, 5'd0, 32'h0, 32'h0);
      total++;
      if (dcache_valid !== 1'b0) begin
         bad++;
         $display("FAIL latency_early: valid=%b at T+1, want 0", dcache_valid);
      end
      tick;
      total++;
      if (dcache_valid !== 1'b1 || dcache_lsqid !== 5'd9 || dcache_rdata !== 32'h0 || dcache_error !== 1'b0) begin
         bad++;
         $display("FAIL first_lw: vld=%b tag=%0d rdata=%h err=%b, want 1/9/00000000/0",
                  dcache_valid, dcache_lsqid, dcache_rdata, dcache_error);
      end
      tick;
   endtask

   task automatic test_store_load;
      drive(1'b1, SW, 5'd3, 32'h20, 32'h12345678);
      tick;
      drive(1'b1, LB, 5'd4, 32'h23, 32'h0);
      tick;
      drive(1'b1, LHU, 5'd5, 32'h20, 32'h0);
      total++;
      if (dcache_valid !== 1'b1 || dcache_lsqid !== 5'd3 || dcache_rdata !== 32'h0 || dcache_error !== 1'b0) begin
         bad++;
         $display("FAIL sw_resp: vld=%b tag=%0d rdata=%h err=%b, want 1/3/00000000/0",
                  dcache_valid, dcache_lsqid, dcache_rdata, dcache_error);
      end
      tick;
      drive(1'b0, LB, 5'd0, 32'h0, 32'h0);
      total++;
      if (dcache_valid !== 1'b1 || dcache_lsqid !== 5'd4 || dcache_rdata !== 32'h00000012 || dcache_error !== 1'b0) begin
         bad++;
         $display("FAIL lb_fwd: vld=%b tag=%0d rdata=%h err=%b, want 1/4/00000012/0",
                  dcache_valid, dcache_lsqid, dcache_rdata, dcache_error);
      end
      tick;
      total++;
      if (dcache_valid !== 1'b1 || dcache_lsqid !== 5'd5 || dcache_rdata !== 32'h00005678 || dcache_error !== 1'b0) begin
         bad++;
         $display("FAIL lhu: vld=%b tag=%0d rdata=%h err=%b, want 1/5/00005678/0",
                  dcache_valid, dcache_lsqid, dcache_rdata, dcache_error);
      end
      tick;
      total++;
      if (dcache_valid !== 1'b0) begin
         bad++;
         $display("FAIL drain: valid=%b after last response, want 0", dcache_valid);
      end
   endtask

   task automatic test_sign_ext;
      drive(1'b1, SB, 5'd6, 32'h31, 32'hABCDEF80);
      tick;
      drive(1'b1, LB, 5'd7, 32'h31, 32'h0);
      tick;
      drive(1'b1, LBU, 5'd8, 32'h31, 32'h0);
      tick;
      drive(1'b1, LW, 5'd9, 32'h30, 32'h0);
      total++;
      if (dcache_valid !== 1'b1 || dcache_lsqid !== 5'd7 || dcache_rdata !== 32'hFFFFFF80) begin
         bad++;
         $display("FAIL lb_sign: vld=%b tag=%0d rdata=%h, want 1/7/ffffff80", dcache_valid, dcache_lsqid, dcache_rdata);
      end
      tick;
      drive(1'b0, LB, 5'd0, 32'h0, 32'h0);
      total++;
      if (dcache_valid !== 1'b1 || dcache_lsqid !== 5'd8 || dcache_rdata !== 32'h00000080) begin
         bad++;
         $display("FAIL lbu_zero: vld=%b tag=%0d rdata=%h, want 1/8/00000080", dcache_valid, dcache_lsqid, dcache_rdata);
      end
      tick;
      total++;
      if (dcache_valid !== 1'b1 || dcache_lsqid !== 5'd9 || dcache_rdata !== 32'h00008000) begin
         bad++;
         $display("FAIL sb_lane_only: vld=%b tag=%0d rdata=%h, want 1/9/00008000", dcache_valid, dcache_lsqid, dcache_rdata);
      end
      tick;
   endtask

   task automatic test_errors;
      drive(1'b1, SW, 5'd6, 32'h1040, 32'hDEADBEEF);
      tick;
      drive(1'b1, LW, 5'd7, 32'h1000, 32'h0);
      tick;
      drive(1'b1, LW, 5'd8, 32'h40, 32'h0);
      total++;
      if (dcache_valid !== 1'b1 || dcache_lsqid !== 5'd6 || dcache_error !== 1'b1 || dcache_rdata !== 32'h0) begin
         bad++;
         $display("FAIL sw_range: vld=%b tag=%0d err=%b rdata=%h, want 1/6/1/00000000",
                  dcache_valid, dcache_lsqid, dcache_error, dcache_rdata);
      end
      tick;
      drive(1'b1, 4'h3, 5'd10, 32'h40, 32'h0);
      total++;
      if (dcache_valid !== 1'b1 || dcache_lsqid !== 5'd7 || dcache_error !== 1'b1 || dcache_rdata !== 32'h0) begin
         bad++;
         $display("FAIL lw_range: vld=%b tag=%0d err=%b rdata=%h, want 1/7/1/00000000",
                  dcache_valid, dcache_lsqid, dcache_error, dcache_rdata);
      end
      tick;
      drive(1'b0, LB, 5'd0, 32'h0, 32'h0);
      total++;
      if (dcache_valid !== 1'b1 || dcache_lsqid !== 5'd8 || dcache_error !== 1'b0 || dcache_rdata !== 32'h0) begin
         bad++;
         $display("FAIL lw_after_err: vld=%b tag=%0d err=%b rdata=%h, want 1/8/0/00000000",
                  dcache_valid, dcache_lsqid, dcache_error, dcache_rdata);
      end
      tick;
      total++;
      if (dcache_valid !== 1'b1 || dcache_lsqid !== 5'd10 || dcache_error !== 1'b1 || dcache_rdata !== 32'h0) begin
         bad++;
         $display("FAIL illegal_op: vld=%b tag=%0d err=%b rdata=%h, want 1/10/1/00000000",
                  dcache_valid, dcache_lsqid, dcache_error, dcache_rdata);
      end
      tick;
   endtask

   task automatic test_flush;
      // load killed in S1, request in flush cycle refused
      drive(1'b1, LW, 5'd1, 32'h20, 32'h0);
      tick;
      lsq_dc_flush = 1'b1;
      drive(1'b1, LW, 5'd2, 32'h20, 32'h0);
      total++;
      if (dcache_ready !== 1'b0) begin
         bad++;
         $display("FAIL flush_ready_f: ready=%b in flush cycle, want 0", dcache_ready);
      end
      tick;
      lsq_dc_flush = 1'b0;
      drive(1'b1, LW, 5'd10, 32'h20, 32'h0);
      total++;
      if (dcache_ready !== 1'b0 || dcache_valid !== 1'b0) begin
         bad++;
         $display("FAIL flush_state: rdy=%b vld=%b in F+1, want 0/0", dcache_ready, dcache_valid);
      end
      tick;
      drive(1'b0, LB, 5'd0, 32'h0, 32'h0);
      total++;
      if (dcache_ready !== 1'b1 || dcache_valid !== 1'b0) begin
         bad++;
         $display("FAIL flush_recover: rdy=%b vld=%b in F+2, want 1/0", dcache_ready, dcache_valid);
      end
      tick;
      total++;
      if (dcache_valid !== 1'b0) begin
         bad++;
         $display("FAIL flush_no_resp: vld=%b tag=%0d in F+3, want 0", dcache_valid, dcache_lsqid);
      end
      tick;
      // store in S1 survives flush
      drive(1'b1, SW, 5'd11, 32'h24, 32'hCAFEF00D);
      tick;
      lsq_dc_flush = 1'b1;
      drive(1'b1, LW, 5'd2, 32'h24, 32'h0);
      tick;
      lsq_dc_flush = 1'b0;
      drive(1'b0, LB, 5'd0, 32'h0, 32'h0);
      total++;
      if (dcache_valid !== 1'b1 || dcache_lsqid !== 5'd11 || dcache_error !== 1'b0 || dcache_rdata !== 32'h0) begin
         bad++;
         $display("FAIL flush_store_resp: vld=%b tag=%0d err=%b rdata=%h, want 1/11/0/00000000",
                  dcache_valid, dcache_lsqid, dcache_error, dcache_rdata);
      end
      tick;
      drive(1'b1, LW, 5'd12, 32'h24, 32'h0);
      tick;
      drive(1'b0, LB, 5'd0, 32'h0, 32'h0);
      tick;
      total++;
      if (dcache_valid !== 1'b1 || dcache_lsqid !== 5'd12 || dcache_rdata !== 32'hCAFEF00D) begin
         bad++;
         $display("FAIL flush_store_data: vld=%b tag=%0d rdata=%h, want 1/12/cafef00d", dcache_valid, dcache_lsqid, dcache_rdata);
      end
      tick;
      // response already registered is delivered; flush held two cycles extends FLUSH
      drive(1'b1, LW, 5'd13, 32'h20, 32'h0);
      tick;
      drive(1'b1, LW, 5'd14, 32'h24, 32'h0);
      tick;
      lsq_dc_flush = 1'b1;
      drive(1'b0, LB, 5'd0, 32'h0, 32'h0);
      total++;
      if (dcache_valid !== 1'b1 || dcache_lsqid !== 5'd13 || dcache_rdata !== 32'h12345678) begin
         bad++;
         $display("FAIL flush_deliver: vld=%b tag=%0d rdata=%h, want 1/13/12345678", dcache_valid, dcache_lsqid, dcache_rdata);
      end
      tick;
      total++;
      if (dcache_valid !== 1'b0) begin
         bad++;
         $display("FAIL flush_kill2: vld=%b tag=%0d, want 0", dcache_valid, dcache_lsqid);
      end
      tick;
      lsq_dc_flush = 1'b0;
      #1;
      total++;
      if (dcache_ready !== 1'b0) begin
         bad++;
         $display("FAIL flush_extend: ready=%b, want 0", dcache_ready);
      end
      tick;
      total++;
      if (dcache_ready !== 1'b1 || dcache_valid !== 1'b0) begin
         bad++;
         $display("FAIL flush_extend_end: rdy=%b vld=%b, want 1/0", dcache_ready, dcache_valid);
      end
   endtask

   task automatic test_align;
      logic [31:0] exp_word;
      drive(1'b1, LW, 5'd15, 32'h22, 32'h0);
      tick;
      drive(1'b1, SH, 5'd16, 32'h21, 32'h0000BEEF);
      tick;
      drive(1'b0, LB, 5'd0, 32'h0, 32'h0);
      total++;
`ifdef DCACHE_ALIGN_CHECK_EN
      if (dcache_valid !== 1'b1 || dcache_lsqid !== 5'd15 || dcache_error !== 1'b1 || dcache_rdata !== 32'h0) begin
         bad++;
         $display("FAIL lw_misalign: vld=%b tag=%0d err=%b rdata=%h, want 1/15/1/00000000",
                  dcache_valid, dcache_lsqid, dcache_error, dcache_rdata);
      end
      exp_word = 32'h12345678;
`else
      if (dcache_valid !== 1'b1 || dcache_lsqid !== 5'd15 || dcache_error !== 1'b0 || dcache_rdata !== 32'h12345678) begin
         bad++;
         $display("FAIL lw_misalign: vld=%b tag=%0d err=%b rdata=%h, want 1/15/0/12345678",
                  dcache_valid, dcache_lsqid, dcache_error, dcache_rdata);
      end
      exp_word = 32'h1234BEEF;
`endif
      tick;
      drive(1'b1, LW, 5'd17, 32'h20, 32'h0);
      tick;
      drive(1'b0, LB, 5'd0, 32'h0, 32'h0);
      tick;
      total++;
      if (dcache_valid !== 1'b1 || dcache_lsqid !== 5'd17 || dcache_rdata !== exp_word) begin
         bad++;
         $display("FAIL sh_misalign_write: vld=%b tag=%0d rdata=%h, want 1/17/%h", dcache_valid, dcache_lsqid, dcache_rdata, exp_word);
      end
      tick;
   endtask

   task automatic test_mid_reset;
      int not_zero;
      drive(1'b1, LW, 5'd18, 32'h20, 32'h0);
      tick;
      rst = 1'b1;
      drive(1'b0, LB, 5'd0, 32'h0, 32'h0);
      tick;
      total++;
      if (dcache_valid !== 1'b0 || dcache_ready !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_discard: vld=%b rdy=%b, want 0/0", dcache_valid, dcache_ready);
      end
      rst = 1'b0;
      drive(1'b1, LW, 5'd19, 32'h20, 32'h0);
      not_zero = 0;
      for (int i = 0; i < 1024; i++) begin
         lsq_dc_flush = (i == 5 || i == 1023);
         #1;
         if (dcache_ready !== 1'b0 || dcache_valid !== 1'b0) not_zero++;
         tick;
      end
      lsq_dc_flush = 1'b0;
      #1;
      total++;
      if (not_zero !== 0 || dcache_ready !== 1'b1) begin
         bad++;
         $display("FAIL reinit: %0d bad init cycles, ready=%b at 1024, want 0/1", not_zero, dcache_ready);
      end
      tick;
      drive(1'b0, LB, 5'd0, 32'h0, 32'h0);
      tick;
      total++;
      if (dcache_valid !== 1'b1 || dcache_lsqid !== 5'd19 || dcache_rdata !== 32'h0) begin
         bad++;
         $display("FAIL reinit_zeroed: vld=%b tag=%0d rdata=%h, want 1/19/00000000", dcache_valid, dcache_lsqid, dcache_rdata);
      end
      tick;
   endtask

   initial begin
      test_reset;
      test_store_load;
      test_sign_ext;
      test_errors;
      test_flush;
      test_align;
      test_mid_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
